// File: rtl/atm_ledger_arbiter.sv
// ---------------------------------------------------------------------------
// atm_ledger_arbiter
//
// Shares one account-ledger memory between N_TERM ATM terminal front-ends.
// A round-robin arbiter grants one terminal request at a time. The granted
// transaction (inquiry, deposit or withdraw) runs as a read-modify-write
// sequence on the ledger. Each transaction ends with a one-cycle
// status/balance response to the requesting terminal.
//
// Optional feature: define ATM_TIMEOUT_EN to abort a ledger read that gets
// no data within TIMEOUT cycles. The aborted transaction responds with ERROR
// and balance 0. Without the macro, WAIT holds indefinitely.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req             per-terminal request, held until that terminal's resp_valid
//   req_card        flattened card numbers, terminal i at [i*BAL_W +: BAL_W]
//   req_service     flattened 2-bit service codes (00 inq, 01 dep, 10 wdr, 11 illegal)
//   req_amount      flattened transaction amounts, AMT_W bits each
//   resp_valid      one-cycle one-hot response pulse to the granted terminal
//   resp_status     00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 ERROR
//   resp_balance    resulting balance
//   busy            high in every state except IDLE
//   mem_rd_en       one-cycle ledger read strobe
//   mem_addr        ledger address (card number), held from RD through WR
//   mem_rd_data     ledger read data, sampled on mem_rd_valid
//   mem_rd_valid    read-data strobe
//   mem_wr_en       one-cycle ledger write strobe
//   mem_wr_data     ledger write data
// ---------------------------------------------------------------------------
module atm_ledger_arbiter #(
  parameter int N_TERM  = 4,
  parameter int BAL_W   = 8,
  parameter int AMT_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_TERM-1:0]         req,
  input  logic [N_TERM*BAL_W-1:0]   req_card,
  input  logic [N_TERM*2-1:0]       req_service,
  input  logic [N_TERM*AMT_W-1:0]   req_amount,
  output logic [N_TERM-1:0]         resp_valid,
  output logic [1:0]                resp_status,
  output logic [BAL_W-1:0]          resp_balance,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [BAL_W-1:0]          mem_addr,
  input  logic [BAL_W-1:0]          mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic                      mem_wr_en,
  output logic [BAL_W-1:0]          mem_wr_data
);

  localparam int IDX_W = $clog2(N_TERM);

  localparam logic [1:0] SVC_INQ = 2'b00;
  localparam logic [1:0] SVC_DEP = 2'b01;
  localparam logic [1:0] SVC_WDR = 2'b10;
  localparam logic [1:0] SVC_ILL = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_UPD  = 3'd3,
    S_WR   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      win_q;
  logic [1:0]            svc_q;
  logic [AMT_W-1:0]      amt_q;
  logic [BAL_W-1:0]      bal_q;
  logic [BAL_W-1:0]      res_q;

  logic [N_TERM-1:0]     resp_valid_q;
  logic [1:0]            resp_status_q;
  logic [BAL_W-1:0]      resp_balance_q;
  logic                  busy_q;
  logic                  mem_rd_en_q;
  logic [BAL_W-1:0]      mem_addr_q;
  logic                  mem_wr_en_q;
  logic [BAL_W-1:0]      mem_wr_data_q;

  logic                  found_s;
  logic [IDX_W-1:0]      win_s;
  logic [BAL_W-1:0]      card_s;
  logic [1:0]            svc_s;
  logic [AMT_W-1:0]      amt_s;

  logic [BAL_W:0]        sum_s;
  logic [BAL_W-1:0]      amt_ext_s;
  logic [BAL_W-1:0]      upd_res_s;
  logic [1:0]            upd_st_s;
  logic                  upd_wr_s;

`ifdef ATM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      to_cnt_q;
`else
  // TIMEOUT only matters when the read-wait abort is built.
  logic                  timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
`endif

  // One-hot response vector for a terminal index.
  function automatic logic [N_TERM-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Pointer to the terminal after idx, wrapping at N_TERM-1.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_TERM - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  // Round-robin search starting at ptr_q; first requesting terminal wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    found_s = 1'b0;
    win_s   = '0;
    idx     = '0;
    for (int k = 0; k < N_TERM; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % N_TERM);
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        win_s   = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner's request fields.
  always_comb begin
    card_s = req_card[win_s*BAL_W +: BAL_W];
    svc_s  = req_service[win_s*2 +: 2];
    amt_s  = req_amount[win_s*AMT_W +: AMT_W];
  end

  // Ledger update: deposits use one extra bit so the carry flags overflow.
  always_comb begin
    sum_s     = {1'b0, bal_q} + {{(BAL_W+1-AMT_W){1'b0}}, amt_q};
    amt_ext_s = {{(BAL_W-AMT_W){1'b0}}, amt_q};
    upd_res_s = bal_q;
    upd_st_s  = ST_OK;
    upd_wr_s  = 1'b0;
    case (svc_q)
      SVC_INQ: begin
        upd_st_s = ST_OK;
      end
      SVC_DEP: begin
        if (sum_s[BAL_W]) begin
          upd_st_s = ST_OVF;
        end else begin
          upd_res_s = sum_s[BAL_W-1:0];
          upd_wr_s  = 1'b1;
        end
      end
      SVC_WDR: begin
        if (amt_ext_s > bal_q) begin
          upd_st_s = ST_INSUF;
        end else begin
          upd_res_s = bal_q - amt_ext_s;
          upd_wr_s  = 1'b1;
        end
      end
      default: begin
        // Illegal services are rejected in IDLE and never reach UPD.
        upd_st_s  = ST_ERR;
        upd_res_s = '0;
      end
    endcase
  end

  // Transaction FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      win_q          <= '0;
      svc_q          <= 2'b00;
      amt_q          <= '0;
      bal_q          <= '0;
      res_q          <= '0;
      resp_valid_q   <= '0;
      resp_status_q  <= 2'b00;
      resp_balance_q <= '0;
      busy_q         <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_wr_data_q  <= '0;
`ifdef ATM_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      resp_valid_q <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_s) begin
            win_q  <= win_s;
            svc_q  <= svc_s;
            amt_q  <= amt_s;
            busy_q <= 1'b1;
            if ((card_s == '0) || (svc_s == SVC_ILL)) begin
              // Rejected before touching the ledger.
              state_q        <= S_RESP;
              resp_valid_q   <= onehot(win_s);
              resp_status_q  <= ST_ERR;
              resp_balance_q <= '0;
            end else begin
              state_q     <= S_RD;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= card_s;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RD: begin
          state_q <= S_WAIT;
`ifdef ATM_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            bal_q   <= mem_rd_data;
            state_q <= S_UPD;
`ifdef ATM_TIMEOUT_EN
          end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT cycles spent in WAIT with no data: abort with ERROR.
            state_q        <= S_RESP;
            resp_valid_q   <= onehot(win_q);
            resp_status_q  <= ST_ERR;
            resp_balance_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
`else
          end else begin
            state_q <= S_WAIT;
`endif
          end
        end
        S_UPD: begin
          if (upd_wr_s) begin
            state_q       <= S_WR;
            res_q         <= upd_res_s;
            mem_wr_en_q   <= 1'b1;
            mem_wr_data_q <= upd_res_s;
          end else begin
            state_q        <= S_RESP;
            resp_valid_q   <= onehot(win_q);
            resp_status_q  <= upd_st_s;
            resp_balance_q <= upd_res_s;
          end
        end
        S_WR: begin
          state_q        <= S_RESP;
          resp_valid_q   <= onehot(win_q);
          resp_status_q  <= ST_OK;
          resp_balance_q <= res_q;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= next_idx(win_q);
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_status  = resp_status_q;
  assign resp_balance = resp_balance_q;
  assign busy         = busy_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wr_data  = mem_wr_data_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// ---------------------------------------------------------------------------
// tb_atm_ledger_arbiter
//
// Directed scoreboard bench for atm_ledger_arbiter (N_TERM=4, BAL_W=8,
// AMT_W=5, TIMEOUT=16). Stimulus pushes hand-computed expected responses
// into a queue; a monitor pops and compares on every resp_valid pulse,
// also tracking read/write strobes and response timing.
// The ATM_TIMEOUT_EN section runs only when that macro is defined.
// ---------------------------------------------------------------------------
module tb_atm_ledger_arbiter;

  localparam int NT = 4;

  logic            clk;
  logic            rst;
  logic [NT-1:0]   req;
  logic [NT*8-1:0] req_card;
  logic [NT*2-1:0] req_service;
  logic [NT*5-1:0] req_amount;
  logic [NT-1:0]   resp_valid;
  logic [1:0]      resp_status;
  logic [7:0]      resp_balance;
  logic            busy;
  logic            mem_rd_en;
  logic [7:0]      mem_addr;
  logic [7:0]      mem_rd_data;
  logic            mem_rd_valid;
  logic            mem_wr_en;
  logic [7:0]      mem_wr_data;

  atm_ledger_arbiter #(.N_TERM(4), .BAL_W(8), .AMT_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_card(req_card),
    .req_service(req_service), .req_amount(req_amount),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_balance(resp_balance), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  typedef struct {
    int         term;
    logic [1:0] st;
    logic [7:0] bal;
    int         rd;
    int         wr;
    logic [7:0] card;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ledger [256];
  int         n_checks;
  int         n_pass;
  int         cyc;
  int         lat;
  bit         mute;

  localparam logic [1:0] OK = 2'b00, INSUF = 2'b01, OVF = 2'b10, ERR = 2'b11;
  localparam logic [1:0] INQ = 2'b00, DEP = 2'b01, WDR = 2'b10, ILL = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Ledger memory model: answers each read strobe after lat cycles.
  initial begin
    logic [7:0] a;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd_en && !mute && !rst) begin
        a = mem_addr;
        repeat (lat) @(negedge clk);
        mem_rd_data  = ledger[a];
        mem_rd_valid = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0;
      end
    end
  end

  // Monitor: counts strobes and checks each response against the scoreboard.
  initial begin
    exp_t       e;
    int         rd_n;
    int         wr_n;
    logic [7:0] wd;
    logic [7:0] ra;
    rd_n = 0; wr_n = 0; wd = 8'h00; ra = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_n = 0;
        wr_n = 0;
      end else begin
        if (mem_rd_en) begin
          rd_n++;
          ra = mem_addr;
        end
        if (mem_wr_en) begin
          wr_n++;
          wd = mem_wr_data;
          ledger[mem_addr] = mem_wr_data;
        end
        if (resp_valid != 4'b0000) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_resp", {28'h0, resp_valid}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            chk("resp_valid_onehot", {28'h0, resp_valid}, 32'h1 << e.term);
            chk("resp_status", {30'h0, resp_status}, {30'h0, e.st});
            chk("resp_balance", {24'h0, resp_balance}, {24'h0, e.bal});
            chk("busy_in_resp", {31'h0, busy}, 32'h1);
            chk("rd_strobes", rd_n, e.rd);
            chk("wr_strobes", wr_n, e.wr);
            if (e.rd > 0) chk("mem_addr", {24'h0, ra}, {24'h0, e.card});
            if (e.wr > 0) chk("mem_wr_data", {24'h0, wd}, {24'h0, e.bal});
            if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
          end
          rd_n = 0;
          wr_n = 0;
        end
      end
    end
  end

  task automatic set_fields(input int t, input logic [7:0] card, input logic [1:0] svc,
                            input logic [4:0] amt);
    req_card[t*8 +: 8]    = card;
    req_service[t*2 +: 2] = svc;
    req_amount[t*5 +: 5]  = amt;
  endtask

  task automatic push_exp(input int t, input logic [1:0] st, input logic [7:0] bal,
                          input int rd, input int wr, input logic [7:0] card, input int c);
    exp_t e;
    e.term = t; e.st = st; e.bal = bal; e.rd = rd; e.wr = wr; e.card = card; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Single transaction; elat is the response cycle relative to the sampling cycle.
  task automatic do_txn(input int t, input logic [7:0] card, input logic [1:0] svc,
                        input logic [4:0] amt, input int l, input logic [1:0] est,
                        input logic [7:0] ebal, input int erd, input int ewr, input int elat);
    int t0;
    bit got;
    lat = l;
    @(negedge clk);
    t0 = cyc;
    push_exp(t, est, ebal, erd, ewr, card, t0 + elat);
    set_fields(t, card, svc, amt);
    req[t] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[t]) got = 1'b1;
    end
    if (!got) chk("resp_wait", {31'h0, resp_valid[t]}, 32'h1);
    req[t] = 1'b0;
  endtask

  // Several terminals request together; served bits drop, optionally re-raise.
  task automatic run_group(input logic [3:0] mask, input int count, input bit reraise);
    int n;
    n = 0;
    req = mask;
    for (int i = 0; i < 400 && n < count; i++) begin
      @(negedge clk);
      if (resp_valid != 4'b0000) begin
        n++;
        if (n == count) req = 4'b0000;
        else req = req & ~resp_valid;
      end else if (reraise) begin
        req = mask;
      end
    end
    if (n != count) chk("group_resp_count", n, count);
    req = 4'b0000;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_resp_valid"}, {28'h0, resp_valid}, 32'h0);
    chk({tag, "_resp_status"}, {30'h0, resp_status}, 32'h0);
    chk({tag, "_resp_balance"}, {24'h0, resp_balance}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_mem_rd_en"}, {31'h0, mem_rd_en}, 32'h0);
    chk({tag, "_mem_addr"}, {24'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_wr_en"}, {31'h0, mem_wr_en}, 32'h0);
    chk({tag, "_mem_wr_data"}, {24'h0, mem_wr_data}, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; lat = 1; mute = 1'b0;
    rst = 1'b1; req = 4'b0000;
    req_card = '0; req_service = '0; req_amount = '0;
    for (int i = 0; i < 256; i++) ledger[i] = 8'h00;
    ledger[8'h05] = 8'd20;
    ledger[8'h07] = 8'd12;
    ledger[8'h09] = 8'd250;
    ledger[8'h11] = 8'h40; ledger[8'h12] = 8'h41;
    ledger[8'h13] = 8'h42; ledger[8'h14] = 8'h43;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // term, card, svc, amt, L, status, balance, reads, writes, resp cycle
    do_txn(0, 8'h05, DEP, 5'd10, 1, OK,    8'd30,  1, 1, 5);
    do_txn(1, 8'h07, WDR, 5'd31, 2, INSUF, 8'd12,  1, 0, 5);
    do_txn(2, 8'h07, WDR, 5'd12, 2, OK,    8'd0,   1, 1, 6);
    do_txn(3, 8'h09, DEP, 5'd10, 3, OVF,   8'd250, 1, 0, 6);
    do_txn(0, 8'h09, DEP, 5'd5,  1, OK,    8'd255, 1, 1, 5);
    do_txn(1, 8'h09, INQ, 5'd0,  2, OK,    8'd255, 1, 0, 5);
    do_txn(2, 8'h00, DEP, 5'd3,  1, ERR,   8'd0,   0, 0, 1);
    do_txn(3, 8'h05, ILL, 5'd3,  1, ERR,   8'd0,   0, 0, 1);

    // Last winner was terminal 3, so the search restarts at 0.
    lat = 1;
    for (int t = 0; t < 4; t++) set_fields(t, 8'h11 + 8'(t), INQ, 5'd0);
    push_exp(0, OK, 8'h40, 1, 0, 8'h11, -1);
    push_exp(1, OK, 8'h41, 1, 0, 8'h12, -1);
    push_exp(2, OK, 8'h42, 1, 0, 8'h13, -1);
    push_exp(3, OK, 8'h43, 1, 0, 8'h14, -1);
    push_exp(0, OK, 8'h40, 1, 0, 8'h11, -1);
    @(negedge clk);
    run_group(4'b1111, 5, 1'b1);

    // Reset while waiting on the ledger: no write, no response, ptr back to 0.
    mute = 1'b1;
    @(negedge clk);
    set_fields(2, 8'h05, DEP, 5'd1);
    req[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_in_wait", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    mute = 1'b0;

    // Terminal 0 wins over terminal 1 right after reset.
    set_fields(0, 8'h11, INQ, 5'd0);
    set_fields(1, 8'h12, INQ, 5'd0);
    push_exp(0, OK, 8'h40, 1, 0, 8'h11, -1);
    push_exp(1, OK, 8'h41, 1, 0, 8'h12, -1);
    @(negedge clk);
    run_group(4'b0011, 2, 1'b0);

`ifdef ATM_TIMEOUT_EN
    // Memory never answers: ERROR 16 cycles after entering WAIT.
    mute = 1'b1;
    do_txn(1, 8'h05, INQ, 5'd0, 1, ERR, 8'd0, 1, 0, 18);
    @(negedge clk);
    chk("idle_after_timeout", {31'h0, busy}, 32'h0);
    mute = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
